// File: rtl/signal_cfg_pkg.sv
// signal_cfg_pkg -- shared constants and types for the cfg shadow block.
//   Field widths, header/component bit offsets inside the packed cfg word,
//   component stride, default calibration values, and the FSM state enum.
package signal_cfg_pkg;

  localparam int W_FIELD     = 48;   // nominal width of freq/cfg/phase fields
  localparam int W_AMP       = 16;
  localparam int W_HDR16     = 16;   // offset / calib fields

  // Header layout
  localparam int HDR_W          = 128;
  localparam int HDR_RAMP_OFF   = 0;
  localparam int HDR_OFFSET_OFF = 48;
  localparam int HDR_CSCALE_OFF = 64;
  localparam int HDR_COFF_OFF   = 80;

  // Per-component layout, relative to HDR_W + COMP_STRIDE*k
  localparam int COMP_STRIDE    = 256;
  localparam int COMP_CFG_OFF   = 0;
  localparam int COMP_AMP_OFF   = 48;
  localparam int COMP_FREQ_OFF  = 64;
  localparam int COMP_PHASE_OFF = 128;

  // Unity gain / zero offset when calibration is not configurable
  localparam logic [W_HDR16-1:0] CALIB_SCALE_DFLT  = 16'h8000;
  localparam logic [W_HDR16-1:0] CALIB_OFFSET_DFLT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/signal_cfg_field_unpack.sv
// signal_cfg_field_unpack -- combinational extraction of one waveform
// component's fields from its 256-bit slice of the cfg word.
//   i_slice : 256-bit component slice
//   o_cfg   : cfg field   (W bits at +0)
//   o_amp   : amplitude   (16 bits at +48)
//   o_freq  : frequency   (W bits at +64)
//   o_phase : phase       (W bits at +128)
// W is expected to be <= 48 so the fields do not overlap.
module signal_cfg_field_unpack
  import signal_cfg_pkg::*;
#(
  parameter int W = 48
) (
  input  logic [COMP_STRIDE-1:0] i_slice,
  output logic [W-1:0]           o_cfg,
  output logic [W_AMP-1:0]       o_amp,
  output logic [W-1:0]           o_freq,
  output logic [W-1:0]           o_phase
);

  // Gaps between fields are reserved; fold them into a sink.
  logic w_unused;

  assign o_cfg    = i_slice[COMP_CFG_OFF   +: W];
  assign o_amp    = i_slice[COMP_AMP_OFF   +: W_AMP];
  assign o_freq   = i_slice[COMP_FREQ_OFF  +: W];
  assign o_phase  = i_slice[COMP_PHASE_OFF +: W];
  assign w_unused = ^i_slice;

endmodule

// File: rtl/signal_cfg_shadow.sv
// signal_cfg_shadow -- double-buffered waveform configuration.
//   update_req captures cfg_data into a shadow set; the shadow is copied to
//   the active outputs either right away (SYNC_COMMIT=0) or on the next
//   sync_pulse (SYNC_COMMIT=1), so the generator never sees a torn config.
// Ports:
//   aclk, reset          : clock, synchronous active-high reset
//   cfg_data             : packed header (128b) + N_COMP x 256b components
//   update_req           : capture request pulse
//   sync_pulse           : waveform period boundary
//   ramp_freq, offset    : active header fields
//   calib_scale/offset   : active calibration (constant unless enabled)
//   comp_cfg/freq/phase  : N_COMP x W_FREQ, component k at [k*W_FREQ +: W_FREQ]
//   comp_amp             : N_COMP x 16
//   pending              : shadow holds uncommitted data
//   commit_pulse         : one cycle, coincides with new active values
//   overrun              : sticky, shadow re-captured before commit
//   commit_count         : commits since reset, wraps
// Build option: define SIGNAL_CFG_CALIB_EN to shadow calib_scale/calib_offset
//   from cfg bits [95:64]; otherwise they are fixed at 16'h8000 / 16'h0000.
module signal_cfg_shadow
  import signal_cfg_pkg::*;
#(
  parameter int N_COMP      = 4,
  parameter int SYNC_COMMIT = 1,
  parameter int W_FREQ      = 48
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [HDR_W+COMP_STRIDE*N_COMP-1:0] cfg_data,
  input  logic                              update_req,
  input  logic                              sync_pulse,
  output logic [W_FREQ-1:0]                 ramp_freq,
  output logic [W_HDR16-1:0]                offset,
  output logic [W_HDR16-1:0]                calib_scale,
  output logic [W_HDR16-1:0]                calib_offset,
  output logic [N_COMP*W_FREQ-1:0]          comp_cfg,
  output logic [N_COMP*W_FREQ-1:0]          comp_freq,
  output logic [N_COMP*W_FREQ-1:0]          comp_phase,
  output logic [N_COMP*W_AMP-1:0]           comp_amp,
  output logic                              pending,
  output logic                              commit_pulse,
  output logic                              overrun,
  output logic [15:0]                       commit_count
);

  // ---------------- unpack ----------------
  logic [N_COMP-1:0][W_FREQ-1:0] w_cfg, w_freq, w_phase;
  logic [N_COMP-1:0][W_AMP-1:0]  w_amp;

  for (genvar k = 0; k < N_COMP; k++) begin : g_comp
    signal_cfg_field_unpack #(.W(W_FREQ)) u_unpack (
      .i_slice (cfg_data[HDR_W + COMP_STRIDE*k +: COMP_STRIDE]),
      .o_cfg   (w_cfg[k]),
      .o_amp   (w_amp[k]),
      .o_freq  (w_freq[k]),
      .o_phase (w_phase[k])
    );
  end

  logic w_unused;
  assign w_unused = ^{cfg_data[HDR_W-1:0], sync_pulse};

  // ---------------- control ----------------
  cfg_state_e  r_state;
  logic        r_pending, r_commit_pulse, r_overrun;
  logic [15:0] r_commit_count;
  logic        w_commit_go, w_do_commit;

  assign w_commit_go = (SYNC_COMMIT == 0) ? 1'b1 : sync_pulse;
  // A fresh update_req in PENDING wins over the commit: the newer data
  // stays pending and is committed on the following opportunity.
  assign w_do_commit = (r_state == ST_PENDING) && !update_req && w_commit_go;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pending      <= 1'b0;
      r_commit_pulse <= 1'b0;
      r_overrun      <= 1'b0;
      r_commit_count <= '0;
    end else begin
      r_commit_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // sync_pulse alone (or together with update_req) never commits here
          if (update_req) begin
            r_state   <= ST_PENDING;
            r_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (update_req) begin
            r_overrun <= 1'b1;
          end else if (w_do_commit) begin
            r_state        <= ST_COMMIT;
            r_pending      <= 1'b0;
            r_commit_pulse <= 1'b1;
            r_commit_count <= r_commit_count + 16'd1;
          end
        end
        ST_COMMIT: begin
          // Commit already landed on entry; a new request just starts over.
          if (update_req) begin
            r_state   <= ST_PENDING;
            r_pending <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- shadow / active data ----------------
  logic [W_FREQ-1:0]             r_sh_ramp,   r_act_ramp;
  logic [W_HDR16-1:0]            r_sh_offset, r_act_offset;
  logic [N_COMP-1:0][W_FREQ-1:0] r_sh_cfg,   r_act_cfg;
  logic [N_COMP-1:0][W_FREQ-1:0] r_sh_freq,  r_act_freq;
  logic [N_COMP-1:0][W_FREQ-1:0] r_sh_phase, r_act_phase;
  logic [N_COMP-1:0][W_AMP-1:0]  r_sh_amp,   r_act_amp;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_sh_ramp   <= '0;
      r_sh_offset <= '0;
      r_sh_cfg    <= '0;
      r_sh_freq   <= '0;
      r_sh_phase  <= '0;
      r_sh_amp    <= '0;
    end else if (update_req) begin
      r_sh_ramp   <= cfg_data[HDR_RAMP_OFF +: W_FREQ];
      r_sh_offset <= cfg_data[HDR_OFFSET_OFF +: W_HDR16];
      r_sh_cfg    <= w_cfg;
      r_sh_freq   <= w_freq;
      r_sh_phase  <= w_phase;
      r_sh_amp    <= w_amp;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_act_ramp   <= '0;
      r_act_offset <= '0;
      r_act_cfg    <= '0;
      r_act_freq   <= '0;
      r_act_phase  <= '0;
      r_act_amp    <= '0;
    end else if (w_do_commit) begin
      r_act_ramp   <= r_sh_ramp;
      r_act_offset <= r_sh_offset;
      r_act_cfg    <= r_sh_cfg;
      r_act_freq   <= r_sh_freq;
      r_act_phase  <= r_sh_phase;
      r_act_amp    <= r_sh_amp;
    end
  end

`ifdef SIGNAL_CFG_CALIB_EN
  logic [W_HDR16-1:0] r_sh_cscale, r_sh_coff, r_act_cscale, r_act_coff;

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_sh_cscale  <= '0;
      r_sh_coff    <= '0;
      r_act_cscale <= '0;
      r_act_coff   <= '0;
    end else begin
      if (update_req) begin
        r_sh_cscale <= cfg_data[HDR_CSCALE_OFF +: W_HDR16];
        r_sh_coff   <= cfg_data[HDR_COFF_OFF   +: W_HDR16];
      end
      if (w_do_commit) begin
        r_act_cscale <= r_sh_cscale;
        r_act_coff   <= r_sh_coff;
      end
    end
  end

  assign calib_scale  = r_act_cscale;
  assign calib_offset = r_act_coff;
`else
  assign calib_scale  = CALIB_SCALE_DFLT;
  assign calib_offset = CALIB_OFFSET_DFLT;
`endif

  // ---------------- outputs ----------------
  assign ramp_freq    = r_act_ramp;
  assign offset       = r_act_offset;
  assign comp_cfg     = r_act_cfg;
  assign comp_freq    = r_act_freq;
  assign comp_phase   = r_act_phase;
  assign comp_amp     = r_act_amp;
  assign pending      = r_pending;
  assign commit_pulse = r_commit_pulse;
  assign overrun      = r_overrun;
  assign commit_count = r_commit_count;

endmodule

// File: tb/tb_signal_cfg_shadow.sv
// Directed bench: one sync-commit instance (N_COMP=8) and one
// immediate-commit instance (N_COMP=4) sharing clock and reset.
module tb_signal_cfg_shadow;

  localparam int W  = 48;
  localparam int NS = 8;
  localparam int NI = 4;

`ifdef SIGNAL_CFG_CALIB_EN
  localparam logic [15:0] EXP_CSCALE = 16'h1111;
`else
  localparam logic [15:0] EXP_CSCALE = 16'h8000;
`endif

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic reset;

  int n_chk  = 0;
  int n_fail = 0;

  // sync instance
  logic [128+256*NS-1:0] s_cfg;
  logic                  s_upd, s_sync;
  logic [W-1:0]          s_ramp;
  logic [15:0]           s_off, s_cs, s_co, s_cnt;
  logic [NS*W-1:0]       s_ccfg, s_cfreq, s_cphase;
  logic [NS*16-1:0]      s_camp;
  logic                  s_pend, s_cp, s_ovr;

  // immediate instance
  logic [128+256*NI-1:0] i_cfg;
  logic                  i_upd, i_sync;
  logic [W-1:0]          i_ramp;
  logic [15:0]           i_off, i_cs, i_co, i_cnt;
  logic [NI*W-1:0]       i_ccfg, i_cfreq, i_cphase;
  logic [NI*16-1:0]      i_camp;
  logic                  i_pend, i_cp, i_ovr;

  signal_cfg_shadow #(.N_COMP(NS), .SYNC_COMMIT(1), .W_FREQ(W)) u_sync (
    .aclk(aclk), .reset(reset), .cfg_data(s_cfg), .update_req(s_upd),
    .sync_pulse(s_sync), .ramp_freq(s_ramp), .offset(s_off),
    .calib_scale(s_cs), .calib_offset(s_co), .comp_cfg(s_ccfg),
    .comp_freq(s_cfreq), .comp_phase(s_cphase), .comp_amp(s_camp),
    .pending(s_pend), .commit_pulse(s_cp), .overrun(s_ovr),
    .commit_count(s_cnt)
  );

  signal_cfg_shadow #(.N_COMP(NI), .SYNC_COMMIT(0), .W_FREQ(W)) u_imm (
    .aclk(aclk), .reset(reset), .cfg_data(i_cfg), .update_req(i_upd),
    .sync_pulse(i_sync), .ramp_freq(i_ramp), .offset(i_off),
    .calib_scale(i_cs), .calib_offset(i_co), .comp_cfg(i_ccfg),
    .comp_freq(i_cfreq), .comp_phase(i_cphase), .comp_amp(i_camp),
    .pending(i_pend), .commit_pulse(i_cp), .overrun(i_ovr),
    .commit_count(i_cnt)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    s_cfg  = '0; s_upd = 1'b0; s_sync = 1'b0;
    i_cfg  = '0; i_upd = 1'b0; i_sync = 1'b0;
    tick; tick;
    reset = 1'b0;

    // reset state
    chk("rst_s_ramp",  s_ramp, 48'h0);
    chk("rst_s_pend",  s_pend, 1'b0);
    chk("rst_s_cp",    s_cp,   1'b0);
    chk("rst_s_ovr",   s_ovr,  1'b0);
    chk("rst_s_cnt",   s_cnt,  16'h0);
    chk("rst_s_phase7", s_cphase[7*W +: W], 48'h0);
    chk("rst_i_amp0",  i_camp[15:0], 16'h0);

    // immediate commit: update at t -> commit at t+2
    i_cfg[47:0]  = 48'h1234;
    i_cfg[79:64] = 16'h1111;
    i_upd = 1'b1;
    tick;                       // t+1
    i_upd = 1'b0;
    chk("imm_t1_pend", i_pend, 1'b1);
    chk("imm_t1_ramp", i_ramp, 48'h0);
    chk("imm_t1_cp",   i_cp,   1'b0);
    tick;                       // t+2
    chk("imm_t2_ramp", i_ramp, 48'h1234);
    chk("imm_t2_cp",   i_cp,   1'b1);
    chk("imm_t2_cnt",  i_cnt,  16'd1);
    chk("imm_t2_pend", i_pend, 1'b0);
    chk("imm_cscale",  i_cs,   EXP_CSCALE);
    tick;
    chk("imm_t3_cp",   i_cp,   1'b0);
    chk("imm_t3_ramp", i_ramp, 48'h1234);

    // sync commit: update at t, sync at t+10, commit visible at t+11
    s_cfg[47:0]  = 48'hA5A5_0000_1111;
    s_cfg[63:48] = 16'h7777;
    s_cfg[79:64] = 16'h1111;
    s_cfg[128 + 256*7 + 128 +: 48] = 48'hABCDEF;
    s_upd = 1'b1;
    tick;                       // t+1
    s_upd = 1'b0;
    chk("syn_t1_pend", s_pend, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick;                     // t+2 .. t+10
      chk("syn_hold_ramp", s_ramp, 48'h0);
      chk("syn_hold_cp",   s_cp,   1'b0);
    end
    s_sync = 1'b1;
    tick;                       // t+11
    s_sync = 1'b0;
    chk("syn_ramp",   s_ramp, 48'hA5A5_0000_1111);
    chk("syn_off",    s_off,  16'h7777);
    chk("syn_cp",     s_cp,   1'b1);
    chk("syn_cnt",    s_cnt,  16'd1);
    chk("syn_pend",   s_pend, 1'b0);
    chk("syn_phase7", s_cphase[7*W +: W], 48'hABCDEF);
    chk("syn_phase0", s_cphase[0 +: W],   48'h0);
    chk("syn_cscale", s_cs,   EXP_CSCALE);
    tick;
    chk("syn_cp_end", s_cp, 1'b0);

    // sync in IDLE does nothing
    s_sync = 1'b1;
    tick;
    s_sync = 1'b0;
    chk("idle_sync_cp",  s_cp,  1'b0);
    chk("idle_sync_cnt", s_cnt, 16'd1);

    // update + sync together in IDLE: capture only
    s_cfg[47:0] = 48'h1;
    s_upd = 1'b1; s_sync = 1'b1;
    tick;
    s_upd = 1'b0; s_sync = 1'b0;
    chk("us_pend", s_pend, 1'b1);
    chk("us_cp",   s_cp,   1'b0);
    tick;
    chk("us_ramp_hold", s_ramp, 48'hA5A5_0000_1111);
    s_sync = 1'b1;
    tick;                       // now in COMMIT
    s_sync = 1'b0;
    chk("us_ramp", s_ramp, 48'h1);
    chk("us_cnt",  s_cnt,  16'd2);

    // update during the commit cycle: no overrun, new data pends
    s_cfg[47:0] = 48'h2;
    s_upd = 1'b1;
    tick;
    s_upd = 1'b0;
    chk("cu_pend", s_pend, 1'b1);
    chk("cu_ovr",  s_ovr,  1'b0);
    chk("cu_ramp", s_ramp, 48'h1);
    s_sync = 1'b1;
    tick;
    s_sync = 1'b0;
    chk("cu_ramp2", s_ramp, 48'h2);
    chk("cu_cnt",   s_cnt,  16'd3);
    tick;

    // double update before sync: last wins, overrun sticks
    s_cfg[128+48 +: 16] = 16'h0100;
    s_upd = 1'b1;
    tick;
    s_cfg[128+48 +: 16] = 16'h0200;
    tick;
    s_upd = 1'b0;
    chk("ov_ovr",  s_ovr, 1'b1);
    chk("ov_amp0_hold", s_camp[15:0], 16'h0);
    s_sync = 1'b1;
    tick;
    s_sync = 1'b0;
    chk("ov_amp0", s_camp[15:0], 16'h0200);
    chk("ov_cnt",  s_cnt, 16'd4);
    tick;
    chk("ov_sticky", s_ovr, 1'b1);

    // reset while pending discards the shadow
    s_cfg[47:0] = 48'h3;
    s_upd = 1'b1;
    tick;                       // t+1
    s_upd = 1'b0;
    tick;                       // t+2
    tick;                       // t+3
    reset = 1'b1;
    tick;                       // t+4
    reset = 1'b0;
    tick;                       // t+5
    s_sync = 1'b1;
    tick;                       // t+6
    s_sync = 1'b0;
    chk("rp_cp",   s_cp,   1'b0);
    chk("rp_pend", s_pend, 1'b0);
    chk("rp_ramp", s_ramp, 48'h0);
    chk("rp_amp0", s_camp[15:0], 16'h0);
    chk("rp_phase7", s_cphase[7*W +: W], 48'h0);
    chk("rp_cnt",  s_cnt,  16'h0);
    chk("rp_ovr",  s_ovr,  1'b0);
    chk("rp_i_cnt", i_cnt, 16'h0);
    s_sync = 1'b1;
    tick;
    s_sync = 1'b0;
    chk("rp_cp2",  s_cp,   1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
